// File: rtl/lpm_pkg.sv
// Shared definitions for the LPM divider family: FSM encoding,
// representation strings and a constant-width helper.
package lpm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } lpm_state_e;

   localparam string LPM_SIGNED   = "SIGNED";
   localparam string LPM_UNSIGNED = "UNSIGNED";

   // Ceiling log2, never below 1 so it can size a counter directly.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/lpm_shift_add_step.sv
// One shift-add multiplier step: adds mcand<<k into the accumulator
// when the examined multiplier bit is set.
module lpm_shift_add_step #(
   parameter int ACC_W   = 2,
   parameter int MCAND_W = 1,
   parameter int K_W     = 1
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [MCAND_W-1:0] mcand,
   input  logic               mbit,
   input  logic [K_W-1:0]     k,
   output logic [ACC_W-1:0]   acc_next
);

   logic [ACC_W-1:0] addend;

   always_comb begin
      addend   = ACC_W'(mcand) << k;
      acc_next = mbit ? acc + addend : acc;
   end

endmodule

// File: rtl/lpm_divide_restore.sv
// Rebuilds numer = quotient*denom + remain with a bit-serial shift-add engine.
// Define LPM_DIVIDE_RESTORE_OVF_EN to add the registered ovf output.
module lpm_divide_restore
   import lpm_pkg::*;
#(
   parameter int    lpm_widthn          = 1,
   parameter int    lpm_widthd          = 1,
   parameter string lpm_nrepresentation = "UNSIGNED",
   parameter string lpm_drepresentation = "UNSIGNED"
) (
   input  logic                  clock,
   input  logic                  aclr_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [lpm_widthn-1:0] quotient,
   input  logic [lpm_widthd-1:0] denom,
   input  logic [lpm_widthd-1:0] remain,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [lpm_widthn-1:0] numer
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
  ,output logic                  ovf
`endif
);

   localparam int N    = lpm_widthn;
   localparam int D    = lpm_widthd;
   localparam int AW   = N + D;
   localparam int FW   = N + D + 1;
   localparam int CW   = clog2(D + 1);
   localparam bit NSGN = (lpm_nrepresentation == LPM_SIGNED);
   localparam bit DSGN = (lpm_drepresentation == LPM_SIGNED);

   if (lpm_widthn < 1 || lpm_widthd < 1) begin : g_bad_width
      $error("lpm_divide_restore: lpm_widthn and lpm_widthd must be > 0");
   end
   if (lpm_nrepresentation != LPM_SIGNED && lpm_nrepresentation != LPM_UNSIGNED) begin : g_bad_nrep
      $error("lpm_divide_restore: illegal lpm_nrepresentation");
   end
   if (lpm_drepresentation != LPM_SIGNED && lpm_drepresentation != LPM_UNSIGNED) begin : g_bad_drep
      $error("lpm_divide_restore: illegal lpm_drepresentation");
   end

   lpm_state_e          state, state_nxt;
   logic                armed;
   logic [CW-1:0]       cnt;
   logic [AW-1:0]       acc, acc_next;
   logic [N-1:0]        mcand, q_mag;
   logic [D-1:0]        mult, d_mag;
   logic                sign, sq, sd, take;
   logic signed [AW-1:0] rem_ext, rem_x;
   logic signed [FW-1:0] prod_s, numer_full;

   // armed keeps in_ready low through reset and the edge that releases it
   assign in_ready  = armed && (state == IDLE);
   assign out_valid = (state == DONE);
   assign take      = in_valid && in_ready;

   // Magnitudes fit the unsigned port width, so the most-negative value cannot wrap.
   always_comb begin
      sq    = NSGN && quotient[N-1];
      sd    = DSGN && denom[D-1];
      q_mag = sq ? -quotient : quotient;
      d_mag = sd ? -denom : denom;
      rem_x = DSGN ? AW'($signed(remain)) : AW'(remain);
   end

   lpm_shift_add_step #(
      .ACC_W   (AW),
      .MCAND_W (N),
      .K_W     (CW)
   ) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .mbit     (mult[0]),
      .k        (cnt),
      .acc_next (acc_next)
   );

   always_ff @(posedge clock) begin
      if (take) begin
         acc     <= '0;
         mcand   <= q_mag;
         mult    <= d_mag;
         sign    <= sq ^ sd;
         rem_ext <= rem_x;
      end else if (state == CALC) begin
         acc  <= acc_next;
         mult <= mult >> 1;
      end
   end

   always_comb begin
      prod_s     = sign ? -$signed({1'b0, acc}) : $signed({1'b0, acc});
      numer_full = prod_s + FW'(rem_ext);
   end

`ifdef LPM_DIVIDE_RESTORE_OVF_EN
   function automatic logic fits_n(input logic signed [FW-1:0] v);
      if (NSGN) return (&v[FW-1:N-1]) || !(|v[FW-1:N-1]);
      else      return !(|v[FW-1:N]);
   endfunction
`else
   logic unused_hi;
   assign unused_hi = ^numer_full[FW-1:N];
`endif

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state <= IDLE;
         armed <= 1'b0;
         cnt   <= '0;
         numer <= '0;
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
         if (take)
            cnt <= '0;
         else if (state == CALC)
            cnt <= cnt + CW'(1);
         if (state == FIN) begin
            numer <= numer_full[N-1:0];
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
            ovf   <= !fits_n(numer_full);
`endif
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = CALC;
         CALC:    if (cnt == CW'(D - 1)) state_nxt = FIN;
         FIN:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lpm_divide_restore.sv
// Directed and randomised bench for lpm_divide_restore on three configurations:
// unsigned 8/4, signed 8/4 and unsigned 4/4.
module tb_lpm_divide_restore;

   logic       clock = 1'b0;
   logic       aclr_n = 1'b0;
   logic       iv[3], orr[3], irdy[3], ovld[3];
   logic [7:0] qa[3];
   logic [3:0] da[3], ra[3];
   logic [7:0] num0, num1;
   logic [3:0] num2;
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
   logic       ov[3];
`endif
   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   lpm_divide_restore #(.lpm_widthn(8), .lpm_widthd(4),
      .lpm_nrepresentation("UNSIGNED"), .lpm_drepresentation("UNSIGNED")) u_u84 (
      .clock(clock), .aclr_n(aclr_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .quotient(qa[0]), .denom(da[0]), .remain(ra[0]),
      .out_valid(ovld[0]), .out_ready(orr[0]), .numer(num0)
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
     ,.ovf(ov[0])
`endif
   );

   lpm_divide_restore #(.lpm_widthn(8), .lpm_widthd(4),
      .lpm_nrepresentation("SIGNED"), .lpm_drepresentation("SIGNED")) u_s84 (
      .clock(clock), .aclr_n(aclr_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .quotient(qa[1]), .denom(da[1]), .remain(ra[1]),
      .out_valid(ovld[1]), .out_ready(orr[1]), .numer(num1)
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
     ,.ovf(ov[1])
`endif
   );

   lpm_divide_restore #(.lpm_widthn(4), .lpm_widthd(4),
      .lpm_nrepresentation("UNSIGNED"), .lpm_drepresentation("UNSIGNED")) u_u44 (
      .clock(clock), .aclr_n(aclr_n), .in_valid(iv[2]), .in_ready(irdy[2]),
      .quotient(qa[2][3:0]), .denom(da[2]), .remain(ra[2]),
      .out_valid(ovld[2]), .out_ready(orr[2]), .numer(num2)
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
     ,.ovf(ov[2])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] num_of(input int u);
      case (u)
         0:       return num0;
         1:       return num1;
         default: return {4'h0, num2};
      endcase
   endfunction

   // Reference result computed with plain integer arithmetic.
   function automatic void model(input int u, input logic [7:0] q, input logic [3:0] d,
                                 input logic [3:0] r, output logic [7:0] n, output logic o);
      int full;
      if (u == 1) begin
         full = int'($signed(q)) * int'($signed(d)) + int'($signed(r));
         o = (full < -128) || (full > 127);
      end else begin
         full = int'(q) * int'(d) + int'(r);
         o = (full > 255);
      end
      n = full[7:0];
   endfunction

   task automatic do_op(input int u, input logic [7:0] q, input logic [3:0] d, input logic [3:0] r,
                        input logic [7:0] exp_n, input logic exp_o, input int hold, input string tag);
      int n;
      n = 0;
      while (!irdy[u] && n < 20) begin
         @(posedge clock); #1; n++;
      end
      chk({tag, "/ready_wait"}, 32'(n < 20), 32'd1);
      qa[u] = q; da[u] = d; ra[u] = r; iv[u] = 1'b1;
      @(posedge clock); #1;
      iv[u] = 1'b0;
      chk({tag, "/in_ready_drop"}, 32'(irdy[u]), 32'd0);
      n = 0;
      while (!ovld[u] && n < 20) begin
         @(posedge clock); #1; n++;
      end
      chk({tag, "/latency"}, 32'(n), 32'd5);
      chk({tag, "/numer"}, 32'(num_of(u)), 32'(exp_n));
`ifdef LPM_DIVIDE_RESTORE_OVF_EN
      chk({tag, "/ovf"}, 32'(ov[u]), 32'(exp_o));
`else
      if (exp_o === 1'bx) $display("note: %s has undefined ovf expectation", tag);
`endif
      if (hold > 0) begin
         qa[u] = 8'h55; da[u] = 4'h3; ra[u] = 4'h1; iv[u] = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         chk({tag, "/hold_valid"}, 32'(ovld[u]), 32'd1);
         chk({tag, "/hold_numer"}, 32'(num_of(u)), 32'(exp_n));
         chk({tag, "/hold_ready"}, 32'(irdy[u]), 32'd0);
      end
      iv[u] = 1'b0;
      orr[u] = 1'b1;
      @(posedge clock); #1;
      orr[u] = 1'b0;
      chk({tag, "/out_valid_drop"}, 32'(ovld[u]), 32'd0);
      chk({tag, "/in_ready_back"}, 32'(irdy[u]), 32'd1);
      chk({tag, "/numer_kept"}, 32'(num_of(u)), 32'(exp_n));
   endtask

   initial begin
      logic [7:0] mq, mn;
      logic [3:0] md, mr;
      logic       mo;
      int         u;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; qa[i] = '0; da[i] = '0; ra[i] = '0;
      end

      #3;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset/in_ready%0d", i), 32'(irdy[i]), 32'd0);
         chk($sformatf("reset/out_valid%0d", i), 32'(ovld[i]), 32'd0);
         chk($sformatf("reset/numer%0d", i), 32'(num_of(i)), 32'd0);
      end
      #9 aclr_n = 1'b1;
      #1 chk("release/in_ready_before_edge", 32'(irdy[0]), 32'd0);
      @(posedge clock); #1;
      chk("release/in_ready_after_edge", 32'(irdy[0]), 32'd1);

      do_op(0, 8'd13, 4'd7, 4'd5, 8'd96, 1'b0, 0, "u13x7p5");
      do_op(1, 8'hFD, 4'd5, 4'hE, 8'hEF, 1'b0, 0, "s_m3x5pm2");
      do_op(1, 8'h80, 4'hF, 4'h0, 8'h80, 1'b1, 0, "s_m128xm1");
      do_op(1, 8'd3, 4'h8, 4'h0, 8'hE8, 1'b0, 0, "s_3xm8");
      do_op(1, 8'd77, 4'h0, 4'h9, 8'hF9, 1'b0, 0, "s_d0_rm7");
      do_op(0, 8'd200, 4'd3, 4'd2, 8'h5A, 1'b1, 10, "u_backpressure");
      do_op(0, 8'd77, 4'd0, 4'd9, 8'd9, 1'b0, 0, "u_denom0");
      do_op(0, 8'd0, 4'd11, 4'd9, 8'd9, 1'b0, 0, "u_quot0");
      do_op(2, 8'h0F, 4'hF, 4'hF, 8'h00, 1'b1, 0, "u44_15x15p15");

      // Reset during CALC drops the operation and clears the outputs at once.
      do_op(0, 8'd10, 4'd2, 4'd1, 8'd21, 1'b0, 0, "u_pre_reset");
      qa[0] = 8'd13; da[0] = 4'd7; ra[0] = 4'd5; iv[0] = 1'b1;
      @(posedge clock); #1;
      iv[0] = 1'b0;
      @(posedge clock); #1;
      aclr_n = 1'b0;
      #1;
      chk("midreset/out_valid", 32'(ovld[0]), 32'd0);
      chk("midreset/numer", 32'(num0), 32'd0);
      chk("midreset/in_ready", 32'(irdy[0]), 32'd0);
      @(posedge clock); #1;
      aclr_n = 1'b1;
      @(posedge clock); #1;
      chk("midreset/in_ready_back", 32'(irdy[0]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         chk("midreset/no_output", 32'(ovld[0]), 32'd0);
      end
      do_op(0, 8'd1, 4'd1, 4'd0, 8'd1, 1'b0, 0, "u_after_reset");

      for (int k = 0; k < 1000; k++) begin
         u  = k % 2;
         mq = 8'($urandom_range(0, 255));
         md = 4'($urandom_range(0, 15));
         mr = 4'($urandom_range(0, 15));
         model(u, mq, md, mr, mn, mo);
         do_op(u, mq, md, mr, mn, mo, 0, $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
